// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754-style multiplier with generic exponent/fraction widths.
// Operand register, decode/multiply, normalise/round, special-case/pack; one global stall enable.
`timescale 1ns/1ps
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W+MAN_W:0]       input_a,
    input  logic [EXP_W+MAN_W:0]       input_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       output_z,
    output logic [3:0]                 flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;
    localparam logic [EW2-1:0] BIAS   = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0] MAXE   = EW2'((1 << EXP_W) - 1);
    localparam logic [EW2-1:0] ZERO_E = '0;
    localparam logic [W-1:0]   QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic w_en;

    // Operand register stage
    logic           r_s0_valid;
    logic [W-1:0]   r_s0_a;
    logic [W-1:0]   r_s0_b;

    // Decode / multiply stage
    logic           r_s1_valid;
    logic           r_s1_sign;
    logic [EW2-1:0] r_s1_exp;
    logic [PW-1:0]  r_s1_prod;
    logic           r_s1_nan;
    logic           r_s1_invalid;
    logic           r_s1_inf;
    logic           r_s1_zero;

    // Normalise / round stage
    logic             r_s2_valid;
    logic             r_s2_sign;
    logic [EW2-1:0]   r_s2_exp;
    logic [MAN_W-1:0] r_s2_frac;
    logic             r_s2_inexact;
    logic             r_s2_nan;
    logic             r_s2_invalid;
    logic             r_s2_inf;
    logic             r_s2_zero;

    // Output stage
    logic           r_out_valid;
    logic [W-1:0]   r_out_z;
    logic [3:0]     r_flags;

    assign w_en      = out_ready | ~r_out_valid;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign output_z  = r_out_z;
    assign flags     = r_flags;

    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_a_snan, w_b_snan, w_inf_zero;
    logic [EW2-1:0]   w_e_sum;
    logic [PW-1:0]    w_man_a, w_man_b, w_prod;

    assign w_ea = r_s0_a[W-2:MAN_W];
    assign w_eb = r_s0_b[W-2:MAN_W];
    assign w_fa = r_s0_a[MAN_W-1:0];
    assign w_fb = r_s0_b[MAN_W-1:0];

    // Subnormals count as zero (exponent field 0 regardless of fraction)
    assign w_a_zero   = (w_ea == '0);
    assign w_b_zero   = (w_eb == '0);
    assign w_a_inf    = (w_ea == '1) && (w_fa == '0);
    assign w_b_inf    = (w_eb == '1) && (w_fb == '0);
    assign w_a_nan    = (w_ea == '1) && (w_fa != '0);
    assign w_b_nan    = (w_eb == '1) && (w_fb != '0);
    assign w_a_snan   = w_a_nan && !w_fa[MAN_W-1];
    assign w_b_snan   = w_b_nan && !w_fb[MAN_W-1];
    assign w_inf_zero = (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf);

    assign w_e_sum = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;
    assign w_man_a = {{(MAN_W+1){1'b0}}, 1'b1, w_fa};
    assign w_man_b = {{(MAN_W+1){1'b0}}, 1'b1, w_fb};
    assign w_prod  = w_man_a * w_man_b;

    logic [PW-1:0]    w_norm;
    logic [EW2-1:0]   w_exp_n, w_exp_r;
    logic [MAN_W-1:0] w_frac;
    logic             w_guard, w_sticky, w_inc;
    logic [MAN_W:0]   w_rnd;

    // Product lies in [1,4): left-align so the hidden bit always sits at PW-1
    assign w_norm   = r_s1_prod[PW-1] ? r_s1_prod : (r_s1_prod << 1);
    assign w_exp_n  = r_s1_exp + {{(EW2-1){1'b0}}, r_s1_prod[PW-1]};
    assign w_frac   = w_norm[PW-2 -: MAN_W];
    assign w_guard  = w_norm[MAN_W];
    assign w_sticky = |w_norm[MAN_W-1:0];
    assign w_inc    = w_guard & (w_sticky | w_frac[0]);
    assign w_rnd    = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
    assign w_exp_r  = w_exp_n + {{(EW2-1){1'b0}}, w_rnd[MAN_W]};

    logic [W-1:0] w_z;
    logic [3:0]   w_flags;

    always_comb begin
        w_z     = {r_s2_sign, r_s2_exp[EXP_W-1:0], r_s2_frac};
        w_flags = {3'b000, r_s2_inexact};
        if (r_s2_nan) begin
            w_z     = QNAN;
            w_flags = {r_s2_invalid, 3'b000};
        end else if (r_s2_inf) begin
            w_z     = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags = 4'b0000;
        end else if (r_s2_zero) begin
            w_z     = {r_s2_sign, {(W-1){1'b0}}};
            w_flags = 4'b0000;
        end else if ($signed(r_s2_exp) >= $signed(MAXE)) begin
            w_z     = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags = 4'b0101;
        end else if ($signed(r_s2_exp) <= $signed(ZERO_E)) begin
            w_z     = {r_s2_sign, {(W-1){1'b0}}};
            w_flags = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid   <= 1'b0;
            r_s0_a       <= '0;
            r_s0_b       <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_prod    <= '0;
            r_s1_nan     <= 1'b0;
            r_s1_invalid <= 1'b0;
            r_s1_inf     <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_exp     <= '0;
            r_s2_frac    <= '0;
            r_s2_inexact <= 1'b0;
            r_s2_nan     <= 1'b0;
            r_s2_invalid <= 1'b0;
            r_s2_inf     <= 1'b0;
            r_s2_zero    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_z      <= '0;
            r_flags      <= '0;
        end else if (w_en) begin
            r_s0_valid   <= in_valid;
            r_s0_a       <= input_a;
            r_s0_b       <= input_b;

            r_s1_valid   <= r_s0_valid;
            r_s1_sign    <= r_s0_a[W-1] ^ r_s0_b[W-1];
            r_s1_exp     <= w_e_sum;
            r_s1_prod    <= w_prod;
            r_s1_nan     <= w_a_nan | w_b_nan | w_inf_zero;
            r_s1_invalid <= w_inf_zero | w_a_snan | w_b_snan;
            r_s1_inf     <= w_a_inf | w_b_inf;
            r_s1_zero    <= w_a_zero | w_b_zero;

            r_s2_valid   <= r_s1_valid;
            r_s2_sign    <= r_s1_sign;
            r_s2_exp     <= w_exp_r;
            r_s2_frac    <= w_rnd[MAN_W-1:0];
            r_s2_inexact <= w_guard | w_sticky;
            r_s2_nan     <= r_s1_nan;
            r_s2_invalid <= r_s1_invalid;
            r_s2_inf     <= r_s1_inf;
            r_s2_zero    <= r_s1_zero;

            r_out_valid  <= r_s2_valid;
            r_out_z      <= w_z;
            r_flags      <= w_flags;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: FP32 and FP16 vectors, latency, stall/stream ordering, mid-stream reset.
`timescale 1ns/1ps
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] input_a, input_b, output_z;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_z;
    logic [3:0]  h_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .input_a(input_a), .input_b(input_b), .out_valid(out_valid),
        .out_ready(out_ready), .output_z(output_z), .flags(flags)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .input_a(h_a), .input_b(h_b), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .output_z(h_z), .flags(h_flags)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single transaction on the FP32 instance; called at posedge+1 with the pipe drained
    task automatic mul32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ez, input logic [3:0] ef, input string tag);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        input_a   = a;
        input_b   = b;
        #1;
        check({31'b0, in_ready}, 32'd1, {tag, "_in_ready"});
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check(lat, 32'd3, {tag, "_latency"});
        check(output_z, ez, {tag, "_z"});
        check({28'b0, flags}, {28'b0, ef}, {tag, "_flags"});
    endtask

    task automatic mul16(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ez, input logic [3:0] ef, input string tag);
        int lat;
        h_out_ready = 1'b1;
        h_in_valid  = 1'b1;
        h_a         = a;
        h_b         = b;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 0;
        while (h_out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check(lat, 32'd3, {tag, "_latency"});
        check({16'b0, h_z}, {16'b0, ez}, {tag, "_z"});
        check({28'b0, h_flags}, {28'b0, ef}, {tag, "_flags"});
    endtask

    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic [31:0] sz [8];
    logic [31:0] exp_q [$];

    initial begin
        int sent, got, extra, cyc;
        logic acc, take, prev_stall;
        logic [31:0] prev_z;
        logic [3:0]  prev_f;

        sa = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'hBF800000, 32'h3F000000, 32'h41200000, 32'hC0000000};
        sb = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000,
               32'h40A00000, 32'h3F000000, 32'h41200000, 32'hC0400000};
        sz = '{32'h3F800000, 32'h40800000, 32'h40C00000, 32'h41400000,
               32'hC0A00000, 32'h3E800000, 32'h42C80000, 32'h40C00000};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; input_a = '0; input_b = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check({31'b0, out_valid}, 32'd0, "reset_out_valid");
        check(output_z, 32'd0, "reset_z");
        check({28'b0, flags}, 32'd0, "reset_flags");
        check({31'b0, h_out_valid}, 32'd0, "reset_h_out_valid");
        rst = 1'b0;
        #1;
        check({31'b0, in_ready}, 32'd1, "reset_in_ready");
        @(posedge clk); #1;

        // FP32 directed vectors
        mul32(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "basic");
        mul32(32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001, "rne_tie");
        mul32(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, "rne_sticky");
        mul32(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, "inf_x_zero");
        mul32(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, "qnan");
        mul32(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, "snan");
        mul32(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "neg_inf");
        mul32(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, "overflow");
        mul32(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, "underflow");
        mul32(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, "daz");
        mul32(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, "neg_zero");

        // FP16 instance
        mul16(16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, "h_one");
        mul16(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101, "h_overflow");

        // Stream with out_ready pattern 1-0-0-1
        repeat (2) begin @(posedge clk); #1; end
        sent = 0; got = 0; extra = 0; cyc = 0; prev_stall = 1'b0;
        prev_z = '0; prev_f = '0;
        while (got < 8 && cyc < 200) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                input_a = sa[sent];
                input_b = sb[sent];
            end
            #1;
            check({31'b0, in_ready}, {31'b0, out_ready | ~out_valid}, "in_ready_rule");
            if (prev_stall) begin
                check({31'b0, out_valid}, 32'd1, "stall_valid_hold");
                check(output_z, prev_z, "stall_z_hold");
                check({28'b0, flags}, {28'b0, prev_f}, "stall_flags_hold");
            end
            acc  = in_valid & in_ready;
            take = out_valid & out_ready;
            prev_stall = out_valid & ~out_ready;
            prev_z = output_z;
            prev_f = flags;
            if (take) begin
                if (exp_q.size() == 0) extra++;
                else begin
                    check(output_z, exp_q.pop_front(), "stream_z");
                    got++;
                end
            end
            if (acc) begin
                exp_q.push_back(sz[sent]);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            #1;
            if (out_valid === 1'b1) extra++;
            @(posedge clk); #1;
        end
        check(got, 32'd8, "stream_count");
        check(extra, 32'd0, "stream_extra");

        // Reset with results in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            input_a  = sa[i];
            input_b  = sb[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({31'b0, out_valid}, 32'd1, "pre_reset_valid");
        rst = 1'b1;
        @(posedge clk); #1;
        check({31'b0, out_valid}, 32'd0, "mid_reset_out_valid");
        check({31'b0, in_ready}, 32'd1, "mid_reset_in_ready");
        check(output_z, 32'd0, "mid_reset_z");
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check({31'b0, out_valid}, 32'd0, "post_reset_no_stale");
        end
        mul32(32'hC0000000, 32'hC0400000, 32'h40C00000, 4'b0000, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
